// File: rtl/cfeb_rdout_rcvr.sv
// CFEB readout receiver: frames pushed words into events, decodes 0xB error words,
// and buffers only complete events in a FIFO popped by the DAQMB-side reader.
module cfeb_rdout_rcvr #(
  parameter int TMR       = 0,
  parameter int FIFO_AW   = 6,
  parameter int MAX_WORDS = 100
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [15:0]        DATAIN,
  input  logic               PUSH,
  input  logic               LASTWORD,
  input  logic               DATAAVAIL,
  input  logic               RD,
  output logic [16:0]        DOUT,
  output logic               DVALID,
  output logic               EMPTY,
  output logic               FULL,
  output logic [FIFO_AW:0]   NEVT,
  output logic [2:0]         ERRCODE,
  output logic [7:0]         ERR_CNT,
  output logic               OVFL,
  output logic               LEN_ERR,
  output logic [7:0]         STATUS
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(MAX_WORDS + 1);
  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  localparam logic [CW-1:0]      MAXW  = CW'(MAX_WORDS);
  localparam logic [CW-1:0]      ONE_C = CW'(1);
  localparam logic [FIFO_AW-1:0] ONE_L = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   ONE_P = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    DISCARD = 2'b10
  } state_t;

  state_t           st_q [NCOPY];
  state_t           state;
  state_t           state_next;
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] cptr;
  logic [FIFO_AW:0] rptr;
  logic [CW-1:0]    wcnt;
  logic [CW-1:0]    cnt_next;
  logic [16:0]      mem [DEPTH];

  logic full;
  logic empty;
  logic accept;
  logic force_end;
  logic commit;
  logic word_eoe;
  logic rd_ok;
  logic pop_eoe;
  logic err_word;

  // With TMR the state is held in three copies and majority-voted; otherwise the
  // vote collapses onto the single copy, so cycle behaviour is identical.
  assign state = state_t'((st_q[0] & st_q[NCOPY/2]) |
                          (st_q[0] & st_q[NCOPY-1]) |
                          (st_q[NCOPY/2] & st_q[NCOPY-1]));

  assign empty = (rptr == cptr);
  assign full  = ((wptr[FIFO_AW-1:0] + ONE_L) == rptr[FIFO_AW-1:0]);

  assign accept    = PUSH && !full && (state != DISCARD);
  assign cnt_next  = (state == IDLE) ? ONE_C : (wcnt + ONE_C);
  assign force_end = accept && !LASTWORD && (cnt_next == MAXW);
  assign commit    = accept && (LASTWORD || force_end);
  assign word_eoe  = LASTWORD || force_end;

  assign rd_ok    = RD && !empty;
  assign pop_eoe  = rd_ok && mem[rptr[FIFO_AW-1:0]][16];
  assign err_word = PUSH && (DATAIN[15:12] == 4'hB) && $onehot(DATAIN[11:9]);

  always_comb begin
    state_next = state;
    if (PUSH) begin
      case (state)
        IDLE, COLLECT: begin
          if (full)           state_next = LASTWORD ? IDLE : DISCARD;
          else if (force_end) state_next = DISCARD;
          else if (LASTWORD)  state_next = IDLE;
          else                state_next = COLLECT;
        end
        DISCARD: if (LASTWORD) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Write side: speculative pointer advances per word, committed pointer only at
  // event end; a full FIFO rewinds the partial event back to the last commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCOPY; i++) st_q[i] <= IDLE;
      wptr    <= '0;
      cptr    <= '0;
      wcnt    <= '0;
      OVFL    <= 1'b0;
      LEN_ERR <= 1'b0;
    end else begin
      for (int i = 0; i < NCOPY; i++) st_q[i] <= state_next;
      if (PUSH && (state != DISCARD)) begin
        if (full) begin
          wptr <= cptr;
          OVFL <= 1'b1;
        end else begin
          wptr <= wptr + ONE_P;
          wcnt <= cnt_next;
          if (commit)    cptr    <= wptr + ONE_P;
          if (force_end) LEN_ERR <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[wptr[FIFO_AW-1:0]] <= {word_eoe, DATAIN};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERRCODE <= '0;
      ERR_CNT <= '0;
    end else if (err_word) begin
      ERRCODE <= DATAIN[11:9];
      if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
      rptr   <= '0;
    end else begin
      DVALID <= rd_ok;
      if (rd_ok) begin
        DOUT <= mem[rptr[FIFO_AW-1:0]];
        rptr <= rptr + ONE_P;
      end
    end
  end

  // A commit and an end-of-event pop in the same cycle cancel out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     NEVT <= '0;
    else if (commit && !pop_eoe) NEVT <= NEVT + ONE_P;
    else if (!commit && pop_eoe) NEVT <= NEVT - ONE_P;
  end

  assign EMPTY  = empty;
  assign FULL   = full;
  assign STATUS = {DATAAVAIL, OVFL, LEN_ERR, empty, full, 2'(state), DVALID};

endmodule

// File: tb/tb_cfeb_rdout_rcvr.sv
// Bench for cfeb_rdout_rcvr: two instances (long and short event limit) share stimulus
// and are checked against a queue-based event model, a vector table and directed sequences.
module tb_cfeb_rdout_rcvr;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int MAXW0 = 8;
  localparam int MAXW1 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] datain = '0;
  logic        push = 1'b0;
  logic        last = 1'b0;
  logic        dataavail = 1'b0;
  logic        rd = 1'b0;

  logic [16:0] dout [2];
  logic        dvalid [2];
  logic        empty [2];
  logic        full [2];
  logic [AW:0] nevt [2];
  logic [2:0]  errcode [2];
  logic [7:0]  err_cnt [2];
  logic        ovfl [2];
  logic        len_err [2];
  logic [7:0]  status [2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cfeb_rdout_rcvr #(.TMR(0), .FIFO_AW(AW), .MAX_WORDS(MAXW0)) u0 (
    .CLK(clk), .RST(rst), .DATAIN(datain), .PUSH(push), .LASTWORD(last),
    .DATAAVAIL(dataavail), .RD(rd), .DOUT(dout[0]), .DVALID(dvalid[0]),
    .EMPTY(empty[0]), .FULL(full[0]), .NEVT(nevt[0]), .ERRCODE(errcode[0]),
    .ERR_CNT(err_cnt[0]), .OVFL(ovfl[0]), .LEN_ERR(len_err[0]), .STATUS(status[0])
  );

  cfeb_rdout_rcvr #(.TMR(1), .FIFO_AW(AW), .MAX_WORDS(MAXW1)) u1 (
    .CLK(clk), .RST(rst), .DATAIN(datain), .PUSH(push), .LASTWORD(last),
    .DATAAVAIL(dataavail), .RD(rd), .DOUT(dout[1]), .DVALID(dvalid[1]),
    .EMPTY(empty[1]), .FULL(full[1]), .NEVT(nevt[1]), .ERRCODE(errcode[1]),
    .ERR_CNT(err_cnt[1]), .OVFL(ovfl[1]), .LEN_ERR(len_err[1]), .STATUS(status[1])
  );

  // Reference model: committed words readable by the reader, words of the event
  // still being received, and whether the rest of the current event is being dropped.
  logic [16:0] mq [2][$];
  logic [16:0] mp [2][$];
  bit          mdrop [2];
  bit          movfl [2];
  bit          mlen [2];
  logic [2:0]  mec [2];
  int          mcnt [2];
  logic [16:0] mdout [2];
  bit          mdv [2];

  typedef struct {
    logic        push;
    logic        last;
    logic [15:0] data;
    logic        rd;
    logic        dv;
    logic [16:0] dout;
    logic [AW:0] nevt;
    logic        empty;
    logic [2:0]  ec;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [10];

  function automatic int maxw(int i);
    return (i == 0) ? MAXW0 : MAXW1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mp[i].delete();
      mdrop[i] = 0;
      movfl[i] = 0;
      mlen[i]  = 0;
      mec[i]   = '0;
      mcnt[i]  = 0;
      mdout[i] = '0;
      mdv[i]   = 0;
    end
  endtask

  task automatic move_pending(int i, logic [16:0] tail);
    foreach (mp[i][k]) mq[i].push_back(mp[i][k]);
    mq[i].push_back(tail);
    mp[i].delete();
  endtask

  task automatic model_step(int i, bit p, bit l, logic [15:0] d, bit r);
    int used;
    bit is_full;
    bit is_empty;
    used     = mq[i].size() + mp[i].size();
    is_full  = (used == DEPTH - 1);
    is_empty = (mq[i].size() == 0);
    if (r && !is_empty) begin
      mdout[i] = mq[i].pop_front();
      mdv[i]   = 1;
    end else begin
      mdv[i] = 0;
    end
    if (p) begin
      if (d[15:12] == 4'hB && $countones(d[11:9]) == 1) begin
        mec[i] = d[11:9];
        if (mcnt[i] < 255) mcnt[i]++;
      end
      if (mdrop[i]) begin
        if (l) mdrop[i] = 0;
      end else if (is_full) begin
        mp[i].delete();
        movfl[i] = 1;
        mdrop[i] = !l;
      end else if (l) begin
        move_pending(i, {1'b1, d});
      end else if (mp[i].size() + 1 == maxw(i)) begin
        move_pending(i, {1'b1, d});
        mlen[i]  = 1;
        mdrop[i] = 1;
      end else begin
        mp[i].push_back({1'b0, d});
      end
    end
  endtask

  function automatic int model_events(int i);
    int n = 0;
    foreach (mq[i][k]) if (mq[i][k][16]) n++;
    return n;
  endfunction

  task automatic cmp(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, i, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic       e_empty;
    logic       e_full;
    logic [1:0] e_state;
    logic [7:0] e_status;
    for (int i = 0; i < 2; i++) begin
      e_empty  = (mq[i].size() == 0);
      e_full   = (mq[i].size() + mp[i].size() == DEPTH - 1);
      e_state  = mdrop[i] ? 2'b10 : ((mp[i].size() > 0) ? 2'b01 : 2'b00);
      e_status = {dataavail, movfl[i], mlen[i], e_empty, e_full, e_state, mdv[i]};
      cmp("dout",    i, 32'(dout[i]),    32'(mdout[i]));
      cmp("dvalid",  i, 32'(dvalid[i]),  32'(mdv[i]));
      cmp("empty",   i, 32'(empty[i]),   32'(e_empty));
      cmp("full",    i, 32'(full[i]),    32'(e_full));
      cmp("nevt",    i, 32'(nevt[i]),    32'(model_events(i)));
      cmp("errcode", i, 32'(errcode[i]), 32'(mec[i]));
      cmp("err_cnt", i, 32'(err_cnt[i]), 32'(mcnt[i]));
      cmp("ovfl",    i, 32'(ovfl[i]),    32'(movfl[i]));
      cmp("len_err", i, 32'(len_err[i]), 32'(mlen[i]));
      cmp("status",  i, 32'(status[i]),  32'(e_status));
    end
  endtask

  task automatic applyStimulus(bit p, bit l, logic [15:0] d, bit r);
    push      = p;
    last      = l;
    datain    = d;
    rd        = r;
    dataavail = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_step(0, p, l, d, r);
    model_step(1, p, l, d, r);
    #1;
    checkOutput();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 17'h00000, 4'd1, 1'b0, 3'b000, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 17'h11234, 4'd0, 1'b1, 3'b000, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 17'h11234, 4'd0, 1'b1, 3'b000, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 16'hB9A5, 1'b0, 1'b0, 17'h11234, 4'd0, 1'b1, 3'b100, 8'd1};
    vecs[4] = '{1'b1, 1'b1, 16'hB501, 1'b0, 1'b0, 17'h11234, 4'd1, 1'b0, 3'b010, 8'd2};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 17'h0B9A5, 4'd1, 1'b0, 3'b010, 8'd2};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 17'h1B501, 4'd0, 1'b1, 3'b010, 8'd2};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 17'h1B501, 4'd0, 1'b1, 3'b010, 8'd2};
    vecs[8] = '{1'b1, 1'b1, 16'hB701, 1'b0, 1'b0, 17'h1B501, 4'd1, 1'b0, 3'b010, 8'd2};
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 17'h1B701, 4'd0, 1'b1, 3'b010, 8'd2};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // Single-word event and error-word decode
    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k].push, vecs[k].last, vecs[k].data, vecs[k].rd);
      for (int i = 0; i < 2; i++) begin
        cmp("tbl_dvalid",  i, 32'(dvalid[i]),  32'(vecs[k].dv));
        cmp("tbl_dout",    i, 32'(dout[i]),    32'(vecs[k].dout));
        cmp("tbl_nevt",    i, 32'(nevt[i]),    32'(vecs[k].nevt));
        cmp("tbl_empty",   i, 32'(empty[i]),   32'(vecs[k].empty));
        cmp("tbl_errcode", i, 32'(errcode[i]), 32'(vecs[k].ec));
        cmp("tbl_err_cnt", i, 32'(err_cnt[i]), 32'(vecs[k].cnt));
      end
    end

    // Length limit on the short-limit instance: six words, only four kept
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, k == 6, 16'hA000 + 16'(k), 1'b0);
      if (k == 3) cmp("len_before", 1, 32'(len_err[1]), 32'd0);
      if (k == 4) begin
        cmp("len_after", 1, 32'(len_err[1]), 32'd1);
        cmp("len_nevt",  1, 32'(nevt[1]),    32'd1);
      end
    end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      if (k < 4) cmp("len_word", 1, 32'(dout[1]), 32'({k == 3, 16'hA001 + 16'(k)}));
    end
    applyStimulus(1'b1, 1'b0, 16'h5A01, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h5A02, 1'b0);
    cmp("next_nevt", 1, 32'(nevt[1]), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    cmp("next_w1", 1, 32'(dout[1]), 32'h05A01);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    cmp("next_w2", 1, 32'(dout[1]), 32'h15A02);

    // Overflow on the long-limit instance: 5-word event, then a 4-word event that hits FULL
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, k == 5, 16'hC100 + 16'(k), 1'b0);
    cmp("ovf_nevt0", 0, 32'(nevt[0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, k == 4, 16'hD200 + 16'(k), 1'b0);
      if (k == 2) begin
        cmp("ovf_full",  0, 32'(full[0]), 32'd1);
        cmp("ovf_clear", 0, 32'(ovfl[0]), 32'd0);
      end
      if (k == 3) begin
        cmp("ovf_set",   0, 32'(ovfl[0]),        32'd1);
        cmp("ovf_state", 0, 32'(status[0][2:1]), 32'd2);
      end
      if (k == 4) begin
        cmp("ovf_nevt",  0, 32'(nevt[0]),        32'd1);
        cmp("ovf_idle",  0, 32'(status[0][2:1]), 32'd0);
      end
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      if (k < 5) cmp("ovf_word", 0, 32'(dout[0]), 32'({k == 4, 16'hC101 + 16'(k)}));
      else       cmp("ovf_end",  0, 32'(dvalid[0]), 32'd0);
    end

    // Commit and end-of-event pop in the same cycle, then RD on empty
    applyStimulus(1'b1, 1'b1, 16'h7001, 1'b0);
    cmp("sim_nevt_a", 0, 32'(nevt[0]), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h7002, 1'b1);
    cmp("sim_nevt_b", 0, 32'(nevt[0]), 32'd1);
    cmp("sim_dout_b", 0, 32'(dout[0]), 32'h17001);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    cmp("sim_dout_c", 0, 32'(dout[0]), 32'h17002);
    cmp("sim_nevt_c", 0, 32'(nevt[0]), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    cmp("sim_rd_empty", 0, 32'(dvalid[0]), 32'd0);
    cmp("sim_hold",     0, 32'(dout[0]),   32'h17002);

    // Asynchronous reset while collecting, then a fresh 2-word event
    for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b0, 16'h3000 + 16'(k), 1'b0);
    cmp("rst_collect", 0, 32'(status[0][2:1]), 32'd1);
    push = 1'b0;
    last = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checkOutput();
    for (int i = 0; i < 2; i++) begin
      cmp("rst_ovfl",  i, 32'(ovfl[i]),    32'd0);
      cmp("rst_len",   i, 32'(len_err[i]), 32'd0);
      cmp("rst_cnt",   i, 32'(err_cnt[i]), 32'd0);
      cmp("rst_empty", i, 32'(empty[i]),   32'd1);
    end
    #2 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h4441, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h4442, 1'b0);
    cmp("post_nevt", 0, 32'(nevt[0]), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    cmp("post_w1", 0, 32'(dout[0]), 32'h04441);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    cmp("post_w2", 0, 32'(dout[0]), 32'h14442);

    // Randomized traffic with a bias toward error-word headers
    for (int n = 0; n < 600; n++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d[15:12] = 4'hB;
      applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30, d,
                    $urandom_range(0, 99) < 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
